wr_1000basex_rx_sync: RTL
=========================

WR_1000BASEX_RX_SYNC -- requirements
Module: wr_1000basex_rx_sync

Interface
REQ-001 SHALL have parameter g_comma_count, default 3: aligned comma words needed to acquire sync (range 2..7).
REQ-002 SHALL have parameter g_good_words, default 4: consecutive valid words that recover one error step.
REQ-003 SHALL have port clk_rx_i, input, 1: recovered parallel clock (PHY rx_rbclk); sole clock.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_en_i, input, 1: link enable; low forces loss of sync.
REQ-006 SHALL have port rx_data_i, input, 16: decoded symbols; [15:8] first symbol, [7:0] second.
REQ-007 SHALL have port rx_k_i, input, 2: K flags; [1] for [15:8], [0] for [7:0].
REQ-008 SHALL have port rx_error_i, input, 1: PHY code/disparity error for this word.
REQ-009 SHALL have port rx_data_o, output, 16: registered copy of rx_data_i.
REQ-010 SHALL have port rx_k_o, output, 2: registered copy of rx_k_i.
REQ-011 SHALL have port rx_valid_o, output, 1: rx_data_o/rx_k_o are in-sync and valid.
REQ-012 SHALL have port sync_o, output, 1: link synchronised.
REQ-013 SHALL have port los_cnt_o, output, 16: saturating count of sync-to-loss transitions.
REQ-014 SHALL have port err_cnt_clr_i, input, 1: synchronous clear of err_cnt_o.
REQ-015 SHALL have port err_cnt_o, output, 16: saturating count of invalid words (see Configuration).

Function
REQ-016 Comma word SHALL mean rx_k_i[1]=1 and rx_data_i[15:8]=0xBC (K28.5), rx_error_i=0.
REQ-017 Invalid word SHALL mean any of: rx_error_i=1; a K flag set on a byte not in {1C,3C,5C,7C,9C,BC,DC,FC,F7,FB,FD,FE}; rx_k_i[0]=1 with rx_data_i[7:0]=0xBC (misaligned comma).
REQ-018 States SHALL be LOS, CDET (comma counting), SYNC_0, SYNC_1, SYNC_2; state register updates on each clk_rx_i edge from current inputs.
REQ-019 LOS: comma word -> CDET with comma count 1; otherwise stay.
REQ-020 CDET: invalid word -> LOS; comma word increments count; count reaching g_comma_count -> SYNC_0; non-comma valid words hold count.
REQ-021 SYNC_0: invalid word -> SYNC_1; otherwise stay.
REQ-022 SYNC_1/SYNC_2: invalid word -> next state (SYNC_2 -> LOS) and good count cleared; valid word increments good count; reaching g_good_words -> previous state (SYNC_1 -> SYNC_0) and good count cleared.
REQ-023 rx_en_i=0 SHALL force next state LOS and clear both internal counters, overriding all other transitions.
REQ-024 sync_o SHALL be 1 exactly while state register is SYNC_0/1/2.
REQ-025 rx_data_o/rx_k_o SHALL have 1-cycle latency; rx_valid_o SHALL register (current state in SYNC_x) AND word not invalid, so the final acquiring comma is not flagged valid.
REQ-026 los_cnt_o SHALL increment once on each SYNC_x -> LOS transition (including via rx_en_i), saturating at 0xFFFF.
REQ-027 err_cnt_clr_i and an invalid word in the same cycle SHALL yield err_cnt_o=0 (clear wins).

Reset
REQ-028 rst_n_i low SHALL immediately force state LOS, counters 0, rx_data_o=0, rx_k_o=0, rx_valid_o=0, sync_o=0, los_cnt_o=0, err_cnt_o=0.
REQ-029 Reset mid-acquisition SHALL discard partial comma/good counts; first comma after release restarts at count 1.

Configuration
REQ-030 Macro WR_RX_SYNC_ERRCNT_EN defined: err_cnt_o counts invalid words in any state, saturating at 0xFFFF.
REQ-031 Macro undefined: no error counter logic; err_cnt_o tied to 0, err_cnt_clr_i ignored.

Structure
REQ-032 Package wr_1000basex_pkg SHALL hold the state enum, K-code constants (c_K28_5=0xBC and valid K list) and counter width constant (16).
REQ-033 Word classification (comma/invalid) SHALL be a combinational sub-module wr_1000basex_rx_word_class.

Verification
REQ-034 Reset release, 3 words 0xBC50 k=10 -> sync_o rises on cycle after 3rd word; rx_valid_o 1 from 4th valid word.
REQ-035 In SYNC_0, one word with rx_error_i=1 then 4 valid -> SYNC_1 then SYNC_0; sync_o stays 1; rx_valid_o 0 for error word only.
REQ-036 In SYNC_0, 3 error words within 4 valid -> LOS, sync_o=0, los_cnt_o=1.
REQ-037 In CDET after 2 commas, word 0x50BC k=01 (misaligned) -> LOS; 3 fresh commas required.
REQ-038 In sync, rx_en_i low 1 cycle -> sync_o=0 next cycle, los_cnt_o+1; 0xFFFF los events -> saturates.
REQ-039 With WR_RX_SYNC_ERRCNT_EN, 5 errors then clr coincident with error -> err_cnt_o 5 then 0; without macro err_cnt_o stays 0.

Source files
------------

// File: rtl/wr_1000basex_pkg.sv
// Shared types and constants for the 1000BASE-X receive synchroniser.
// K-code table, state encoding and counter width live here so RTL and tools agree.
package wr_1000basex_pkg;

    typedef enum logic [2:0] {
        ST_LOS    = 3'd0,
        ST_CDET   = 3'd1,
        ST_SYNC_0 = 3'd2,
        ST_SYNC_1 = 3'd3,
        ST_SYNC_2 = 3'd4
    } rx_sync_state_t;

    localparam int          c_CNT_W   = 16;
    localparam logic [7:0]  c_K28_5   = 8'hBC;
    localparam int          c_N_VALID_K = 12;
    localparam logic [7:0]  c_VALID_K [c_N_VALID_K] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
        8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_valid_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < c_N_VALID_K; i++) begin
            if (b == c_VALID_K[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/wr_1000basex_rx_word_class.sv
// Combinational classification of one 16-bit decoded word into comma / invalid.
// Only an upper-byte K28.5 counts as an aligned comma; a lower-byte one is misalignment.
module wr_1000basex_rx_word_class
    import wr_1000basex_pkg::*;
(
    input  logic [15:0] data,
    input  logic [1:0]  k,
    input  logic        error,
    output logic        is_comma,
    output logic        is_invalid
);

    logic bad_k_hi;
    logic bad_k_lo;

    always_comb begin
        bad_k_hi   = k[1] & ~is_valid_k(data[15:8]);
        bad_k_lo   = k[0] & (~is_valid_k(data[7:0]) | (data[7:0] == c_K28_5));
        is_comma   = k[1] & (data[15:8] == c_K28_5) & ~error;
        is_invalid = error | bad_k_hi | bad_k_lo;
    end

endmodule

// File: rtl/wr_1000basex_rx_sync.sv
// 1000BASE-X receive word synchroniser: comma acquisition, error-step loss tracking, counters.
// Define WR_RX_SYNC_ERRCNT_EN to build the invalid-word counter; otherwise err_cnt_o is 0.
//
// state     | meaning
// ST_LOS    | no sync, waiting for an aligned comma
// ST_CDET   | counting aligned commas towards acquisition
// ST_SYNC_0 | synchronised, no outstanding error steps
// ST_SYNC_1 | synchronised, one error step pending recovery
// ST_SYNC_2 | synchronised, two error steps; next invalid word loses sync
module wr_1000basex_rx_sync
    import wr_1000basex_pkg::*;
#(
    parameter int g_comma_count = 3,
    parameter int g_good_words  = 4
) (
    input  logic               clk_rx_i,
    input  logic               rst_n_i,
    input  logic               rx_en_i,
    input  logic [15:0]        rx_data_i,
    input  logic [1:0]         rx_k_i,
    input  logic               rx_error_i,
    output logic [15:0]        rx_data_o,
    output logic [1:0]         rx_k_o,
    output logic               rx_valid_o,
    output logic               sync_o,
    output logic [c_CNT_W-1:0] los_cnt_o,
    input  logic               err_cnt_clr_i,
    output logic [c_CNT_W-1:0] err_cnt_o
);

    localparam int c_GOOD_W = $clog2(g_good_words + 1);

    rx_sync_state_t      state, state_nxt;
    logic [2:0]          comma_cnt, comma_nxt, comma_inc;
    logic [c_GOOD_W-1:0] good_cnt, good_nxt, good_inc;
    logic                is_comma, is_invalid;
    logic                in_sync, los_event;

    wr_1000basex_rx_word_class u_word_class (
        .data       (rx_data_i),
        .k          (rx_k_i),
        .error      (rx_error_i),
        .is_comma   (is_comma),
        .is_invalid (is_invalid)
    );

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_LOS;
            comma_cnt <= '0;
            good_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            comma_cnt <= comma_nxt;
            good_cnt  <= good_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        comma_nxt = comma_cnt;
        good_nxt  = good_cnt;
        comma_inc = comma_cnt + 3'd1;
        good_inc  = good_cnt + 1'b1;
        case (state)
            ST_LOS: begin
                good_nxt = '0;
                if (is_comma) begin
                    state_nxt = ST_CDET;
                    comma_nxt = 3'd1;
                end else begin
                    comma_nxt = '0;
                end
            end
            ST_CDET: begin
                if (is_invalid) begin
                    state_nxt = ST_LOS;
                    comma_nxt = '0;
                end else if (is_comma) begin
                    if (comma_inc == 3'(g_comma_count)) begin
                        state_nxt = ST_SYNC_0;
                        comma_nxt = '0;
                    end else begin
                        comma_nxt = comma_inc;
                    end
                end
            end
            ST_SYNC_0: begin
                good_nxt = '0;
                if (is_invalid) state_nxt = ST_SYNC_1;
            end
            ST_SYNC_1, ST_SYNC_2: begin
                if (is_invalid) begin
                    state_nxt = (state == ST_SYNC_1) ? ST_SYNC_2 : ST_LOS;
                    good_nxt  = '0;
                end else if (good_inc == c_GOOD_W'(g_good_words)) begin
                    state_nxt = (state == ST_SYNC_2) ? ST_SYNC_1 : ST_SYNC_0;
                    good_nxt  = '0;
                end else begin
                    good_nxt = good_inc;
                end
            end
            default: begin
                state_nxt = ST_LOS;
                comma_nxt = '0;
                good_nxt  = '0;
            end
        endcase
        // Link disable overrides every transition above.
        if (!rx_en_i) begin
            state_nxt = ST_LOS;
            comma_nxt = '0;
            good_nxt  = '0;
        end
    end

    always_comb begin
        in_sync   = (state == ST_SYNC_0) || (state == ST_SYNC_1) || (state == ST_SYNC_2);
        los_event = in_sync && (state_nxt == ST_LOS);
        sync_o    = in_sync;
    end

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_data_o  <= '0;
            rx_k_o     <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            rx_data_o  <= rx_data_i;
            rx_k_o     <= rx_k_i;
            rx_valid_o <= in_sync && !is_invalid;
        end
    end

    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            los_cnt_o <= '0;
        end else if (los_event && (los_cnt_o != '1)) begin
            los_cnt_o <= los_cnt_o + 1'b1;
        end
    end

`ifdef WR_RX_SYNC_ERRCNT_EN
    always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt_o <= '0;
        end else if (err_cnt_clr_i) begin
            err_cnt_o <= '0;
        end else if (is_invalid && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end
`else
    logic unused_err_cnt_clr;
    assign unused_err_cnt_clr = err_cnt_clr_i;
    assign err_cnt_o          = '0;
`endif

endmodule
